// File: rtl/mem_responder.sv
// Word-organised responder memory for the rv32 memory bus with byte-masked writes,
// configurable read/write wait states and a sticky out-of-range fault flag.
module mem_responder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_WORDS     = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wmask,
    input  logic                  mem_rstrb,
    output logic [31:0]           mem_rdata,
    output logic                  mem_rbusy,
    output logic                  mem_wbusy,
    output logic                  mem_fault
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [7:0] RD_LAT = 8'(READ_LATENCY);
    localparam logic [7:0] WR_LAT = 8'(WRITE_LATENCY);

    typedef enum logic [1:0] {IDLE, RWAIT, WWAIT} state_t;

    state_t                state, state_n;
    logic [7:0]            cnt;
    logic [31:0]           mem [MEM_WORDS];
    logic [IDX_W-1:0]      req_idx, rd_idx;
    logic                  req_oor, rd_oor;
    logic [ADDR_WIDTH-1:0] addr_hi;
    logic                  wr_req, accept_w, accept_r, rd_done;

    always_comb begin
        addr_hi  = mem_addr >> (IDX_W + 2);
        req_oor  = |addr_hi;
        req_idx  = mem_addr[IDX_W+1:2];
        wr_req   = |mem_wmask;
        accept_w = (state == IDLE) && wr_req;
        accept_r = (state == IDLE) && mem_rstrb && !wr_req;
        rd_done  = (state == RWAIT) && (cnt == 8'd1);
    end

    // Array is never reset; a colliding reset also suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && accept_w && !req_oor) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (mem_wmask[b]) begin
                    mem[req_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_rdata <= '0;
            mem_fault <= 1'b0;
            rd_idx    <= '0;
            rd_oor    <= 1'b0;
        end else begin
            state <= state_n;
            if (accept_w) begin
                cnt <= WR_LAT;
            end else if (accept_r) begin
                cnt    <= RD_LAT;
                rd_idx <= req_idx;
                rd_oor <= req_oor;
            end else if (state != IDLE) begin
                cnt <= cnt - 8'd1;
            end
            if ((accept_w || accept_r) && req_oor) begin
                mem_fault <= 1'b1;
            end
            if (accept_r && READ_LATENCY == 0) begin
                mem_rdata <= req_oor ? '0 : mem[req_idx];
            end else if (rd_done) begin
                mem_rdata <= rd_oor ? '0 : mem[rd_idx];
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept_w) begin
                    state_n = (WRITE_LATENCY > 0) ? WWAIT : IDLE;
                end else if (accept_r) begin
                    state_n = (READ_LATENCY > 0) ? RWAIT : IDLE;
                end
            end
            RWAIT, WWAIT: begin
                if (cnt == 8'd1) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem_rbusy = (state == RWAIT);
        mem_wbusy = (state == WWAIT);
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder: default latencies (2/1) plus a
// zero-latency instance, with hand-written sequences for collisions and resets.
module tb_mem_responder;

    localparam int RL = 2;
    localparam int WL = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wmask;
    logic        rstrb, rbusy, wbusy, fault;

    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [3:0]  z_wmask;
    logic        z_rstrb, z_rbusy, z_wbusy, z_fault;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(32), .MEM_WORDS(1024), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
        .clk(clk), .reset(reset), .mem_addr(addr), .mem_wdata(wdata), .mem_wmask(wmask),
        .mem_rstrb(rstrb), .mem_rdata(rdata), .mem_rbusy(rbusy), .mem_wbusy(wbusy),
        .mem_fault(fault)
    );

    mem_responder #(.ADDR_WIDTH(32), .MEM_WORDS(1024), .READ_LATENCY(0), .WRITE_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .mem_addr(z_addr), .mem_wdata(z_wdata), .mem_wmask(z_wmask),
        .mem_rstrb(z_rstrb), .mem_rdata(z_rdata), .mem_rbusy(z_rbusy), .mem_wbusy(z_wbusy),
        .mem_fault(z_fault)
    );

    typedef struct {
        logic        is_read;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t tbl[12];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // All tasks start and end at a negedge; the request is driven for one cycle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; wdata = d; wmask = m; rstrb = 1'b0;
        @(negedge clk);
        wmask = 4'b0; addr = '0; wdata = '0;
        for (int c = 1; c <= WL; c++) begin
            chk1("wr_wbusy_hi", wbusy, 1'b1);
            chk1("wr_rbusy_lo", rbusy, 1'b0);
            @(negedge clk);
        end
        chk1("wr_wbusy_end", wbusy, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
        addr = a; rstrb = 1'b1; wmask = 4'b0;
        @(negedge clk);
        rstrb = 1'b0; addr = '0;
        for (int c = 1; c <= RL; c++) begin
            chk1("rd_rbusy_hi", rbusy, 1'b1);
            chk1("rd_wbusy_lo", wbusy, 1'b0);
            @(negedge clk);
        end
        chk1("rd_rbusy_end", rbusy, 1'b0);
        chk32("rd_data", rdata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk32("rst_rdata", rdata, 32'h0);
        chk1("rst_rbusy", rbusy, 1'b0);
        chk1("rst_wbusy", wbusy, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk32("rst_z_rdata", z_rdata, 32'h0);
        chk1("rst_z_fault", z_fault, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'hAABB_CCDD, 4'hF, 32'h0,         1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 32'hAA22_CC44, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0013, 32'h0,         4'h0, 32'hAA22_CC44, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0014, 32'h0102_0304, 4'hF, 32'h0,         1'b0};
        tbl[6]  = '{1'b0, 32'h0000_0014, 32'hFFFF_FFFF, 4'h8, 32'h0,         1'b0};
        tbl[7]  = '{1'b1, 32'h0000_0014, 32'h0,         4'h0, 32'hFF02_0304, 1'b0};
        tbl[8]  = '{1'b0, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0FFC, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
        tbl[10] = '{1'b0, 32'h0000_1000, 32'h0000_DEAD, 4'hF, 32'h0,         1'b1};
        tbl[11] = '{1'b1, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         1'b1};

        reset = 1'b1; addr = '0; wdata = '0; wmask = '0; rstrb = 1'b0;
        z_addr = '0; z_wdata = '0; z_wmask = '0; z_rstrb = 1'b0;
        @(negedge clk);
        do_reset();

        // Seed word 0, then reset again: the array must survive reset.
        do_write(32'h0, 32'h0BAD_F00D, 4'hF);

        // Zero-latency instance: back-to-back writes then back-to-back reads.
        for (int i = 0; i < 3; i++) begin
            z_addr = 32'(4 * i); z_wdata = 32'(i + 1); z_wmask = 4'hF;
            @(negedge clk);
            chk1("z_wbusy", z_wbusy, 1'b0);
            chk1("z_rbusy", z_rbusy, 1'b0);
        end
        z_wmask = '0;
        for (int i = 0; i < 3; i++) begin
            z_addr = 32'(4 * i); z_rstrb = 1'b1;
            @(negedge clk);
            chk32("z_rdata", z_rdata, 32'(i + 1));
            chk1("z_rbusy_rd", z_rbusy, 1'b0);
        end
        z_rstrb = 1'b0;

        do_reset();

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].is_read) do_read(tbl[i].a, tbl[i].exp_rdata);
            else do_write(tbl[i].a, tbl[i].d, tbl[i].m);
            chk1("tbl_fault", fault, tbl[i].exp_fault);
        end
        do_read(32'h0, 32'h0BAD_F00D);
        chk1("fault_sticky", fault, 1'b1);

        // Write during WWAIT is ignored.
        addr = 32'h20; wdata = 32'h5; wmask = 4'hF;
        @(negedge clk);
        chk1("busy_w_wbusy", wbusy, 1'b1);
        wdata = 32'h9;
        @(negedge clk);
        wmask = '0;
        chk1("busy_w_idle", wbusy, 1'b0);
        do_read(32'h20, 32'h5);

        // Read strobe during RWAIT adds no busy cycles.
        addr = 32'h20; rstrb = 1'b1;
        @(negedge clk);
        chk1("busy_r_c1", rbusy, 1'b1);
        addr = 32'h10;
        @(negedge clk);
        rstrb = 1'b0;
        chk1("busy_r_c2", rbusy, 1'b1);
        @(negedge clk);
        chk1("busy_r_c3", rbusy, 1'b0);
        chk32("busy_r_data", rdata, 32'h5);
        @(negedge clk);
        chk1("busy_r_c4", rbusy, 1'b0);
        chk32("busy_r_data2", rdata, 32'h5);

        // Simultaneous read + write: write wins, rdata untouched.
        addr = 32'h30; wdata = 32'h7; wmask = 4'hF; rstrb = 1'b1;
        @(negedge clk);
        wmask = '0; rstrb = 1'b0;
        chk1("sim_wbusy", wbusy, 1'b1);
        chk1("sim_rbusy", rbusy, 1'b0);
        @(negedge clk);
        chk1("sim_wbusy_end", wbusy, 1'b0);
        chk32("sim_rdata", rdata, 32'h5);

        // Reset colliding with a write: write is not committed.
        addr = 32'h30; wdata = 32'h8; wmask = 4'hF; reset = 1'b1;
        @(negedge clk);
        wmask = '0; reset = 1'b0;
        chk1("col_wbusy", wbusy, 1'b0);
        chk1("col_fault", fault, 1'b0);
        do_read(32'h30, 32'h7);

        // Reset in the middle of RWAIT loses the pending read.
        addr = 32'h10; rstrb = 1'b1;
        @(negedge clk);
        rstrb = 1'b0;
        chk1("mid_rbusy", rbusy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("mid_rbusy_drop", rbusy, 1'b0);
        chk32("mid_rdata", rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk32("mid_rdata_lost", rdata, 32'h0);
        chk1("mid_rbusy_idle", rbusy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-organised on-chip memory that is the responder end of the core's memory bus: it accepts read strobes and byte-masked writes from `rv32`, serves `mem_rdata`, and drives `mem_rbusy`/`mem_wbusy` to stretch each access by a configurable number of wait states. It sits between the core and block RAM and doubles as the bench memory for core-level simulation.

## Interface
- `ADDR_WIDTH`, 32: width of `mem_addr`.
- `MEM_WORDS`, 1024: depth in 32-bit words; power of two, 4 to 65536.
- `READ_LATENCY`, 2: read wait states, 0–255.
- `WRITE_LATENCY`, 1: write wait states, 0–255.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `mem_addr` in ADDR_WIDTH: byte address; bits [1:0] ignored.
- `mem_wdata` in 32: write data, byte lanes aligned to the mask.
- `mem_wmask` in 4: byte write enables; nonzero requests a write.
- `mem_rstrb` in 1: read request strobe, one cycle.
- `mem_rdata` out 32: read data.
- `mem_rbusy` out 1: read in progress.
- `mem_wbusy` out 1: write in progress.
- `mem_fault` out 1: sticky out-of-range access flag.

## Operation
- States are IDLE, RWAIT and WWAIT. The wait counter is 8 bits.
- **Accept:** requests are accepted only in IDLE. Requests in RWAIT or WWAIT are ignored: no memory access, no state change.
- **Simultaneous request:** if `mem_wmask`≠0 and `mem_rstrb`=1 in the same IDLE cycle, the write is accepted and the read is dropped.
- **Word index:** `mem_addr[log2(MEM_WORDS)+1:2]`.
- **Out of range:** any set bit in `mem_addr[ADDR_WIDTH-1:log2(MEM_WORDS)+2]` makes the access out of range.
  - Reads return 0.
  - Writes are discarded.
  - The handshake timing is unchanged.
  - `mem_fault` is set to 1 and held until reset.
- **Write:**
  - The accept edge commits every byte lane whose mask bit is 1.
  - Lanes with mask bit 0 are unchanged.
  - If WRITE_LATENCY>0, go to WWAIT with counter=WRITE_LATENCY.
- **Read:**
  - The accept edge latches the word index.
  - If READ_LATENCY>0, go to RWAIT with counter=READ_LATENCY.
  - If READ_LATENCY=0, the array is read at the accept edge and `mem_rdata` is updated at that edge.
- **RWAIT/WWAIT:** the counter decrements each cycle. The state returns to IDLE on the edge where the counter goes from 1 to 0. On a read, that same edge loads `mem_rdata` from the array.
- **Data hold:** `mem_rdata` holds its value until the next read completes. Writes never change `mem_rdata`, including writes to the last-read address.
- **Busy outputs:** `mem_rbusy` = (state==RWAIT) and `mem_wbusy` = (state==WWAIT). Both come straight from the state register.
- **Reset values:**
  - State: IDLE.
  - Counter: 0.
  - `mem_rbusy`, `mem_wbusy`: 0.
  - `mem_rdata`: 0x00000000.
  - `mem_fault`: 0.
  - Array contents are not cleared.
- **Reset during operation:** reset aborts RWAIT/WWAIT, and the pending read's data is lost. If reset and an accept occur in the same cycle, reset wins and the write is not committed.

## Timing
- **Read, READ_LATENCY=N>0:**
  - Strobe in cycle 0.
  - `mem_rbusy`=1 in cycles 1..N.
  - `mem_rdata` is valid from cycle N+1, the first cycle with `mem_rbusy`=0.
  - The next request can be accepted in cycle N+1.
- **Read, N=0:** `mem_rbusy` stays 0. Data is valid in cycle 1, and a new request can be accepted in cycle 1.
- **Write, WRITE_LATENCY=M>0:**
  - Array updated at the end of cycle 0.
  - `mem_wbusy`=1 in cycles 1..M.
  - The next request can be accepted in cycle M+1.
- **Write, M=0:** `mem_wbusy` stays 0. Back-to-back writes are possible, one per cycle.
- **Core obligations:**
  - Do not sample busy in the strobe cycle; sample from cycle 1.
  - Hold `mem_addr`/`mem_wdata` only during the strobe cycle.
- Throughput is one access per (latency+1) cycles.

## Test plan
- **Reset, then read:** reset=1 for 2 cycles → all outputs 0. Then read 0x0 with READ_LATENCY=2 → `mem_rbusy` high in cycles 1–2, data valid in cycle 3.
- **Byte-masked write:**
  - Write 0xAABBCCDD to 0x10 with mask 4'b1111.
  - Write 0x11223344 with mask 4'b0101.
  - Read 0x10 → 0xAA22CC44. `mem_wbusy` is high for exactly WRITE_LATENCY cycles after each write.
- **Request during busy:**
  - Write 0x5 to 0x20.
  - Issue a write of 0x9 to 0x20 in cycle 1 of the first write's WWAIT → it is ignored.
  - Read 0x20 → 0x5.
  - Issue a read strobe during RWAIT → no extra busy cycles.
- **Out of range (MEM_WORDS=1024):**
  - Write 0xDEAD to 0x1000 → `mem_fault`=1, and word 0 is still unchanged.
  - Read 0x1000 → 0x0 with normal busy timing.
  - `mem_fault` stays 1 until reset.
- **Zero latency (READ_LATENCY=WRITE_LATENCY=0):**
  - Back-to-back writes of 0x1/0x2/0x3 to 0x0/0x4/0x8, then reads in consecutive cycles → data 0x1/0x2/0x3, each in the cycle after its strobe.
  - Busy never asserts.
- **Simultaneous request and reset collision:**
  - `mem_rstrb`=1 with mask 4'b1111 and data 0x7 at 0x30 → the write is committed and `mem_rdata` is unchanged.
  - Reset asserted in the same cycle as a write of 0x8 to 0x30 → a later read returns 0x7.
  - Reset in the middle of RWAIT → `mem_rbusy` drops the next cycle and `mem_rdata`=0.
